soc_system_pio_in_cond: RTL and testbench

//  Input-conditioning stage directly upstream of the PIO in_port: synchronises asynchronous board inputs,

---
 rtl/soc_system_pio_in_pkg.sv | 23 ++
 rtl/soc_system_pio_in_cond_debounce_bit.sv | 95 +++++++++
 rtl/soc_system_pio_in_cond.sv | 140 ++++++++++++++
 tb/tb_soc_system_pio_in_cond.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_in_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_pio_in_pkg
// Brief    : Shared register map and parameter defaults for the PIO input
//            conditioning stage (soc_system_pio_in_cond).
// Macro    : PIO_IN_COND_DEBOUNCE_EN (consumed by the users of this package)
// Revision : 1.0 - initial release
// ============================================================================
package soc_system_pio_in_pkg;

    // Avalon word addresses of the slave registers
    localparam logic [1:0] ADDR_STABLE    = 2'd0;
    localparam logic [1:0] ADDR_EDGE_MODE = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP  = 2'd3;

    // Parameter defaults for the conditioning stage
    localparam int DEF_WIDTH           = 32;
    localparam int DEF_DEBOUNCE_CYCLES = 50000;
    localparam int DEF_CNT_W           = 16;

endpackage : soc_system_pio_in_pkg
`default_nettype wire

// File: rtl/soc_system_pio_in_cond_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : pio_in_debounce_bit
// Brief    : Two-flop synchroniser followed by a per-bit debounce counter.
//            The new value is accepted only after the synchronised input has
//            differed from the accepted value for DEBOUNCE_CYCLES consecutive
//            cycles; any return to the accepted value restarts the count.
//            Also exports the next accepted value so the parent can detect
//            edges in the same cycle the accepted value changes.
// Macro    : PIO_IN_COND_DEBOUNCE_EN - when undefined the counter is removed
//            and the accepted value follows the synchronised input directly.
// Revision : 1.0 - initial release
// ============================================================================
module pio_in_debounce_bit
    import soc_system_pio_in_pkg::*;
`ifdef PIO_IN_COND_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic stable_nxt
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic stable_q, stable_d;

`ifdef PIO_IN_COND_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchroniser shift and debounce counter next-state
    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == c_cnt_max) begin
                // Held long enough: accept and restart from zero
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers, including the counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    // Synchroniser shift; accepted value simply tracks the synchronised input
    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = sync2_q;
    end

    // State registers without debounce counter
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
        end
    end
`endif

    assign stable     = stable_q;
    assign stable_nxt = stable_d;

endmodule : pio_in_debounce_bit
`default_nettype wire

// File: rtl/soc_system_pio_in_cond.sv
`default_nettype none
// ============================================================================
// Module   : soc_system_pio_in_cond
// Brief    : Input conditioning stage ahead of the PIO in_port. Synchronises
//            and debounces each board input, drives the clean vector to the
//            PIO, and provides per-bit edge capture with a maskable level IRQ
//            behind a small Avalon-MM slave:
//              0 stable (RO), 1 edge_mode (RW), 2 irq_mask (RW),
//              3 edge_capture (write-one-to-clear)
// Macro    : PIO_IN_COND_DEBOUNCE_EN - enables the debounce counters; when
//            undefined the accepted value follows the synchroniser output.
// Revision : 1.0 - initial release
// ============================================================================
module soc_system_pio_in_cond
    import soc_system_pio_in_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] pio_in,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Elaboration-time sanity checks on the configuration
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("soc_system_pio_in_cond: WIDTH must be 1..32");
    end
    if (DEBOUNCE_CYCLES < 1 || CNT_W < 1 ||
        (CNT_W < 31 && (DEBOUNCE_CYCLES - 1) >= (1 << CNT_W))) begin : g_bad_debounce
        $error("soc_system_pio_in_cond: CNT_W cannot hold DEBOUNCE_CYCLES-1");
    end

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_stable_nxt;

    // One synchroniser/debouncer per input bit
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
`ifdef PIO_IN_COND_DEBOUNCE_EN
        pio_in_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk        (clk),
            .reset      (reset),
            .raw        (raw_in[gi]),
            .stable     (w_stable[gi]),
            .stable_nxt (w_stable_nxt[gi])
        );
`else
        pio_in_debounce_bit u_deb (
            .clk        (clk),
            .reset      (reset),
            .raw        (raw_in[gi]),
            .stable     (w_stable[gi]),
            .stable_nxt (w_stable_nxt[gi])
        );
`endif
    end

    logic [WIDTH-1:0] edge_mode_q, edge_mode_d;
    logic [WIDTH-1:0] irq_mask_q,  irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q,  edge_cap_d;
    logic [31:0]      readdata_q,  readdata_d;

    logic             w_write;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;

    // Bus decode, edge detection and register next-state
    always_comb begin
        w_write = chipselect & ~write_n;
        w_wdata = writedata[WIDTH-1:0];

        // Edges are taken against the value being accepted this cycle so the
        // capture bit lands together with the new pio_in value
        w_rise = w_stable_nxt & ~w_stable;
        w_fall = ~w_stable_nxt & w_stable;
        w_set  = w_rise | (w_fall & edge_mode_q);

        w_clr = '0;
        if (w_write && address == ADDR_EDGE_CAP) begin
            w_clr = w_wdata;
        end

        edge_mode_d = edge_mode_q;
        if (w_write && address == ADDR_EDGE_MODE) begin
            edge_mode_d = w_wdata;
        end

        irq_mask_d = irq_mask_q;
        if (w_write && address == ADDR_IRQ_MASK) begin
            irq_mask_d = w_wdata;
        end

        // A new edge beats a simultaneous clear of the same bit
        edge_cap_d = (edge_cap_q & ~w_clr) | w_set;

        // Read mux is evaluated every cycle regardless of chipselect
        case (address)
            ADDR_STABLE:    readdata_d = 32'(w_stable);
            ADDR_EDGE_MODE: readdata_d = 32'(edge_mode_q);
            ADDR_IRQ_MASK:  readdata_d = 32'(irq_mask_q);
            ADDR_EDGE_CAP:  readdata_d = 32'(edge_cap_q);
            default:        readdata_d = 32'd0;
        endcase
    end

    // Register file and read data
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_mode_q <= '0;
            irq_mask_q  <= '0;
            edge_cap_q  <= '0;
            readdata_q  <= '0;
        end else begin
            edge_mode_q <= edge_mode_d;
            irq_mask_q  <= irq_mask_d;
            edge_cap_q  <= edge_cap_d;
            readdata_q  <= readdata_d;
        end
    end

    assign pio_in   = w_stable;
    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule : soc_system_pio_in_cond
`default_nettype wire

// File: tb/tb_soc_system_pio_in_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_system_pio_in_cond
// Brief    : Self-checking bench for soc_system_pio_in_cond (WIDTH=8,
//            DEBOUNCE_CYCLES=4). A reference model predicts pio_in, readdata
//            and irq for every clock; predictions are queued and checked by an
//            independent monitor on the falling edge.
// Macro    : PIO_IN_COND_DEBOUNCE_EN selects the expected acceptance window.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_soc_system_pio_in_cond;
    import soc_system_pio_in_pkg::*;

    localparam int W = 8;
    localparam int D = 4;
`ifdef PIO_IN_COND_DEBOUNCE_EN
    localparam int DM = D;
`else
    localparam int DM = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [W-1:0] raw_in;
    logic [W-1:0] pio_in;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    always #5 clk = ~clk;

    soc_system_pio_in_cond #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .pio_in     (pio_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    typedef struct packed {
        logic [W-1:0] pio;
        logic [31:0]  rd;
        logic         irq;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: a bit is accepted once its last DM synchronised
    // samples all disagree with the currently accepted value.
    logic [W-1:0] m_s1, m_s2, m_stable, m_em, m_mask, m_cap;
    logic [31:0]  m_rd;
    logic [W-1:0] m_hist[$];

    task automatic model_edge();
        logic [W-1:0] st_n, rise, fall, clr, em_n, mask_n;
        bit           wr, all_diff;
        exp_t         e;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0;
            m_em = '0; m_mask = '0; m_cap = '0; m_rd = '0;
            m_hist.delete();
        end else begin
            m_hist.push_back(m_s2);
            if (m_hist.size() > DM) void'(m_hist.pop_front());
            st_n = m_stable;
            for (int i = 0; i < W; i++) begin
                all_diff = (m_hist.size() == DM);
                foreach (m_hist[j]) if (m_hist[j][i] == m_stable[i]) all_diff = 0;
                if (all_diff) st_n[i] = ~m_stable[i];
            end
            rise   = st_n & ~m_stable;
            fall   = ~st_n & m_stable;
            wr     = chipselect && !write_n;
            clr    = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
            em_n   = (wr && address == 2'd1) ? writedata[W-1:0] : m_em;
            mask_n = (wr && address == 2'd2) ? writedata[W-1:0] : m_mask;
            case (address)
                2'd0:    m_rd = {24'd0, m_stable};
                2'd1:    m_rd = {24'd0, m_em};
                2'd2:    m_rd = {24'd0, m_mask};
                default: m_rd = {24'd0, m_cap};
            endcase
            m_cap    = (m_cap & ~clr) | rise | (fall & m_em);
            m_em     = em_n;
            m_mask   = mask_n;
            m_stable = st_n;
            m_s2     = m_s1;
            m_s1     = raw_in;
        end
        e.pio = m_stable;
        e.rd  = m_rd;
        e.irq = |(m_cap & m_mask);
        exp_q.push_back(e);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Monitor: checks every predicted output away from the active edge
    exp_t got_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            got_e = exp_q.pop_front();
            vectors++;
            if (pio_in !== got_e.pio) begin
                miscompares++;
                $display("FAIL pio_in @%0t: got %h expected %h", $time, pio_in, got_e.pio);
            end
            vectors++;
            if (readdata !== got_e.rd) begin
                miscompares++;
                $display("FAIL readdata @%0t: got %h expected %h", $time, readdata, got_e.rd);
            end
            vectors++;
            if (irq !== got_e.irq) begin
                miscompares++;
                $display("FAIL irq @%0t: got %b expected %b", $time, irq, got_e.irq);
            end
        end
    end

    initial begin
        reset = 1'b1; raw_in = 8'hFF; address = 2'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;

        // Reset with inputs already high, then release and watch them commit
        repeat (3) step();
        reset = 1'b0;
        repeat (8) step();
        address = 2'd3;
        repeat (2) step();
        bus_write(2'd3, 32'hFF);
        raw_in = 8'h00;
        repeat (DM + 4) step();

        // Glitch shorter than the window, then a proper hold
        bus_write(2'd3, 32'hFF);
        raw_in[0] = 1'b1; repeat (3) step();
        raw_in[0] = 1'b0; repeat (8) step();
        raw_in[0] = 1'b1; repeat (8) step();

        // Both-edge mode with IRQ enabled, then rise-only mode on a fall
        bus_write(2'd1, 32'h01);
        bus_write(2'd2, 32'h01);
        bus_write(2'd3, 32'hFF);
        raw_in[0] = 1'b0; repeat (8) step();
        bus_write(2'd3, 32'h01);
        bus_write(2'd1, 32'h00);
        raw_in[0] = 1'b1; repeat (8) step();
        bus_write(2'd3, 32'hFF);
        raw_in[0] = 1'b0; repeat (8) step();

        // Clear racing a committing rise, then a plain clear
        raw_in[0] = 1'b1;
        repeat (DM + 1) step();
        bus_write(2'd3, 32'h01);
        step();
        bus_write(2'd3, 32'h01);
        repeat (2) step();

        // Readback truncation and ignored write to the status register
        bus_write(2'd2, 32'hFFFF_FF5A);
        address = 2'd2; repeat (2) step();
        bus_write(2'd0, 32'h0000_0000);
        address = 2'd0; repeat (2) step();

        // Steady rise on bit 3 and a single-cycle pulse on bit 4
        raw_in[3] = 1'b1; repeat (DM + 3) step();
        raw_in[4] = 1'b1; step();
        raw_in[4] = 1'b0; repeat (DM + 4) step();

        // Randomised traffic with occasional mid-debounce resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) raw_in[$urandom_range(0, W - 1)] ^= 1'b1;
            reset      = ($urandom_range(0, 199) == 0);
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 7) == 0);
            write_n    = ~chipselect | ($urandom_range(0, 3) == 0);
            writedata  = $urandom;
            step();
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        repeat (DM + 4) step();

        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_soc_system_pio_in_cond
`default_nettype wire
